ahb_arbiter_n: RTL and testbench
================================

Name: ahb_arbiter_n

Overview:
Parametrised AHB bus arbiter for N masters, generalising the current fixed two-master (IM/DM wrapper) arbitration. It sits beside the AHB address/data muxes and drives one-hot HGRANT plus the address-phase and data-phase owner indices used to steer HADDR/HTRANS/HWDATA. It supports fixed-priority and round-robin modes, honours HLOCK, and enforces a maximum tenure so one master cannot starve the others.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
DEFAULT_MASTER, 0, parking master granted when nobody requests
MAX_HOLD, 16, max address-phase transfers per tenure before forced re-arbitration (0 = unlimited)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
HBUSREQ  in  NUM_MASTERS  per-master bus request
HLOCK  in  NUM_MASTERS  per-master locked-transfer request
HTRANS  in  2  muxed bus HTRANS (current address phase)
HREADY  in  1  muxed bus HREADY
HGRANT  out  NUM_MASTERS  one-hot grant, registered
HMASTER  out  4  address-phase owner index
HMASTER_D  out  4  data-phase owner index (HWDATA/HRDATA steering)
HMASTLOCK  out  1  current address phase is locked

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: HGRANT = one-hot(DEFAULT_MASTER); HMASTER = HMASTER_D = DEFAULT_MASTER; HMASTLOCK = 0; hold counter = 0; RR pointer = DEFAULT_MASTER.
- If rst is asserted mid-transfer, all outputs return to their reset values on the next edge. Any in-flight transfer is abandoned.
- All state updates occur only on clk edges where HREADY = 1. When HREADY = 0, every output and every internal register holds.
- Handover point: an HREADY = 1 edge where at least one of the following holds:
  - (a) the owner's HBUSREQ = 0;
  - (b) HTRANS = IDLE;
  - (c) the hold counter has reached MAX_HOLD and HTRANS is not SEQ/BUSY.
- Handover is suppressed while HMASTLOCK = 1 or while (HLOCK[owner] = 1 and HTRANS != IDLE).
- Selection at a handover point:
  - Fixed mode: lowest set HBUSREQ index wins.
  - RR mode: first set HBUSREQ index searching upward from (HMASTER+1) mod NUM_MASTERS, wrapping around. The current owner is searched last.
  - No requests: DEFAULT_MASTER is granted (bus parking).
- HGRANT is registered and changes on the handover edge.
- HMASTER <= index(HGRANT) and HMASTLOCK <= HLOCK[index(HGRANT)], both on each HREADY = 1 edge. HMASTER therefore lags HGRANT by one HREADY-qualified cycle, per the AHB address-phase rule.
- HMASTER_D <= HMASTER on each HREADY = 1 edge, so the data phase lags the address phase by one.
- Hold counter:
  - Resets to 0 on every edge where HMASTER changes.
  - Increments on each HREADY = 1 edge with HTRANS = NONSEQ or SEQ.
  - Saturates at MAX_HOLD.
  - Ignored when MAX_HOLD = 0.
- Simultaneous events:
  - A lock request and a hold-count expiry arriving together: the lock wins.
  - The owner dropping its request while HLOCK is asserted with HTRANS != IDLE: the grant holds until HTRANS = IDLE.
- A request from an out-of-range or unused index is ignored. Implementations must mask bits ≥ NUM_MASTERS.
- Combinational paths: none from inputs to outputs. All outputs are registers.

Decomposition:
- Shared package ahb_arb_pkg:
  - HTRANS encodings: IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11.
  - Arbitration mode enum (ARB_FIXED, ARB_RR).
  - Master-index width constant (4).
- One sub-module, arb_rr_pick: a combinational priority picker taking the request vector and a start index, returning a one-hot result and an index. It is used in both modes, with start = 0 for fixed mode.

Test Plan:
- Reset/park: hold rst = 1 for 2 cycles with HBUSREQ = 0 -> HGRANT = 4'b0001, HMASTER = 0, HMASTER_D = 0, HMASTLOCK = 0.
- RR fairness: RR_MODE = 1, HBUSREQ = 4'b1111, HTRANS = NONSEQ then IDLE each transfer, HREADY = 1 -> grant sequence 1, 2, 3, 0, 1. Each HMASTER follows HGRANT one cycle later.
- Fixed priority: RR_MODE = 0, HBUSREQ = 4'b1100 then 4'b1110 at a handover -> grant goes 2, then 1. Master 3 is never granted while 1 or 2 request.
- Wait states: with the grant changing and HREADY = 0 for 3 cycles -> HGRANT, HMASTER and HMASTER_D all frozen for those 3 cycles, updating on the first HREADY = 1 edge.
- Lock: master 2 with HLOCK = 1, HTRANS = NONSEQ/SEQ for 20 transfers, MAX_HOLD = 16, master 0 requesting -> no handover until master 2 issues HTRANS = IDLE. HMASTLOCK = 1 throughout.
- Max hold: MAX_HOLD = 4, master 1 issuing back-to-back unlocked NONSEQ, master 3 requesting -> after the 4th transfer, the grant moves to 3 at the next NONSEQ boundary, not mid-SEQ.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// rtl/ahb_arb_pkg.sv - shared AHB arbiter encodings and constants
package ahb_arb_pkg;

    // Width of master index outputs (HMASTER, HMASTER_D); covers up to 16 masters.
    localparam int MIDX_W = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - combinational rotating priority picker
// Ports:
//   req   : request vector, N bits
//   start : index searched first; search proceeds upward and wraps
//   gnt   : one-hot winner (all zero when no request)
//   idx   : winner index
//   valid : at least one request present
import ahb_arb_pkg::*;

module arb_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]      req,
    input  logic [MIDX_W-1:0] start,
    output logic [N-1:0]      gnt,
    output logic [MIDX_W-1:0] idx,
    output logic              valid
);

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        // Offset k from start; the inner loop keeps every req index constant.
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid && req[i] && (((int'(start) + k) % N) == i)) begin
                    valid  = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = MIDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter_n.sv
// rtl/ahb_arbiter_n.sv - N-master AHB arbiter with lock, parking and tenure limit
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   HBUSREQ    : per-master bus request
//   HLOCK      : per-master locked-transfer request
//   HTRANS     : muxed HTRANS of the current address phase
//   HREADY     : muxed HREADY; all state advances only when high
//   HGRANT     : registered one-hot grant
//   HMASTER    : address-phase owner index
//   HMASTER_D  : data-phase owner index
//   HMASTLOCK  : current address phase is locked
import ahb_arb_pkg::*;

module ahb_arbiter_n #(
    parameter int NUM_MASTERS    = 4,
    parameter int RR_MODE        = 1,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MIDX_W-1:0]      HMASTER,
    output logic [MIDX_W-1:0]      HMASTER_D,
    output logic                   HMASTLOCK
);

    localparam arb_mode_e MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;
    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
    localparam logic [MIDX_W-1:0] DEF_IDX = MIDX_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MIDX_W-1:0] LAST_IDX = MIDX_W'(NUM_MASTERS - 1);

    // rr_ptr always holds index(HGRANT); it is the round-robin reference point.
    logic [MIDX_W-1:0]      rr_ptr;
    logic [CNT_W-1:0]       hold_cnt;

    logic                   owner_req;
    logic                   owner_lock;
    logic                   xfer;
    logic                   expired;
    logic                   locked;
    logic                   handover;
    logic [MIDX_W-1:0]      pick_start;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [MIDX_W-1:0]      pick_idx;
    logic                   pick_valid;

    always_comb begin
        owner_req  = |(HBUSREQ & HGRANT);
        owner_lock = |(HLOCK & HGRANT);
        xfer       = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
        // Expiry only counts once the granted master actually owns the address
        // phase; otherwise the stale count of the previous tenure would bounce
        // the grant again on the edge right after a handover.
        expired    = (MAX_HOLD != 0) && (hold_cnt == CNT_MAX) && (rr_ptr == HMASTER) &&
                     (HTRANS != HTRANS_SEQ) && (HTRANS != HTRANS_BUSY);
        // Lock outranks both a dropped request and tenure expiry.
        locked     = HMASTLOCK || (owner_lock && (HTRANS != HTRANS_IDLE));
        handover   = !locked && (!owner_req || (HTRANS == HTRANS_IDLE) || expired);
        pick_start = '0;
        if (MODE == ARB_RR) begin
            pick_start = (rr_ptr == LAST_IDX) ? '0 : rr_ptr + 1'b1;
        end
    end

    arb_rr_pick #(
        .N (NUM_MASTERS)
    ) u_pick (
        .req   (HBUSREQ),
        .start (pick_start),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            HGRANT    <= DEF_GNT;
            rr_ptr    <= DEF_IDX;
            HMASTER   <= DEF_IDX;
            HMASTER_D <= DEF_IDX;
            HMASTLOCK <= 1'b0;
            hold_cnt  <= '0;
        end else if (HREADY) begin
            if (handover) begin
                HGRANT <= pick_valid ? pick_gnt : DEF_GNT;
                rr_ptr <= pick_valid ? pick_idx : DEF_IDX;
            end
            HMASTER   <= rr_ptr;
            HMASTLOCK <= owner_lock;
            HMASTER_D <= HMASTER;
            if (rr_ptr != HMASTER) begin
                hold_cnt <= '0;
            end else if (xfer && (hold_cnt != CNT_MAX)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter_n.sv
// tb/tb_ahb_arbiter_n.sv - directed bench for ahb_arbiter_n
module tb_ahb_arbiter_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] busreq = '0;
    logic [3:0] hlock = '0;
    logic [1:0] htrans = 2'b00;
    logic       hready = 1'b1;

    logic [3:0] g_rr, g_fx, g_mh;
    logic [3:0] m_rr, m_fx, m_mh;
    logic [3:0] md_rr, md_fx, md_mh;
    logic       l_rr, l_fx, l_mh;

    int total = 0;
    int bad = 0;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    always #5 clk = ~clk;

    ahb_arbiter_n #(.NUM_MASTERS(4), .RR_MODE(1), .DEFAULT_MASTER(0), .MAX_HOLD(16)) u_rr (
        .clk(clk), .rst(rst), .HBUSREQ(busreq), .HLOCK(hlock), .HTRANS(htrans),
        .HREADY(hready), .HGRANT(g_rr), .HMASTER(m_rr), .HMASTER_D(md_rr), .HMASTLOCK(l_rr));

    ahb_arbiter_n #(.NUM_MASTERS(4), .RR_MODE(0), .DEFAULT_MASTER(0), .MAX_HOLD(16)) u_fx (
        .clk(clk), .rst(rst), .HBUSREQ(busreq), .HLOCK(hlock), .HTRANS(htrans),
        .HREADY(hready), .HGRANT(g_fx), .HMASTER(m_fx), .HMASTER_D(md_fx), .HMASTLOCK(l_fx));

    ahb_arbiter_n #(.NUM_MASTERS(4), .RR_MODE(1), .DEFAULT_MASTER(0), .MAX_HOLD(4)) u_mh (
        .clk(clk), .rst(rst), .HBUSREQ(busreq), .HLOCK(hlock), .HTRANS(htrans),
        .HREADY(hready), .HGRANT(g_mh), .HMASTER(m_mh), .HMASTER_D(md_mh), .HMASTLOCK(l_mh));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        busreq = '0;
        hlock = '0;
        htrans = T_IDLE;
        hready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    int rr_exp[5] = '{1, 2, 3, 0, 1};
    logic [1:0] mh_trans[9] = '{T_NSEQ, T_SEQ, T_SEQ, T_SEQ, T_NSEQ, T_SEQ, T_SEQ, T_NSEQ, T_NSEQ};
    logic [3:0] mh_gnt[9]   = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                4'b0010, 4'b0010, 4'b1000, 4'b1000};

    initial begin
        int prev;

        // Reset / park
        do_reset();
        check("rst_gnt", g_rr, 4'b0001);
        check("rst_hm", m_rr, 4'd0);
        check("rst_hmd", md_rr, 4'd0);
        check("rst_lock", l_rr, 1'b0);
        check("rst_gnt_mh", g_mh, 4'b0001);

        // Round-robin fairness
        busreq = 4'b1111;
        prev = 0;
        for (int t = 0; t < 5; t++) begin
            htrans = T_NSEQ;
            tick();
            check($sformatf("rr_hm_%0d", t), m_rr, 4'(prev));
            htrans = T_IDLE;
            tick();
            check($sformatf("rr_gnt_%0d", t), g_rr, oh(rr_exp[t]));
            prev = rr_exp[t];
        end

        // Wait states freeze everything
        do_reset();
        busreq = 4'b1000;
        htrans = T_IDLE;
        hready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            check($sformatf("ws_gnt_%0d", t), g_rr, 4'b0001);
            check($sformatf("ws_hm_%0d", t), m_rr, 4'd0);
        end
        hready = 1'b1;
        tick();
        check("ws_gnt_upd", g_rr, 4'b1000);
        check("ws_hm_lag", m_rr, 4'd0);
        hready = 1'b0;
        tick();
        tick();
        check("ws_hm_frz", m_rr, 4'd0);
        hready = 1'b1;
        tick();
        check("ws_hm_upd", m_rr, 4'd3);
        check("ws_hmd_lag", md_rr, 4'd0);
        tick();
        check("ws_hmd_upd", md_rr, 4'd3);

        // Fixed priority
        do_reset();
        busreq = 4'b1100;
        tick();
        check("fx_gnt2", g_fx, 4'b0100);
        tick();
        check("fx_gnt2_hold", g_fx, 4'b0100);
        busreq = 4'b1110;
        tick();
        check("fx_gnt1", g_fx, 4'b0010);
        for (int t = 0; t < 4; t++) begin
            htrans = (t % 2 == 0) ? T_NSEQ : T_IDLE;
            tick();
            check($sformatf("fx_no3_%0d", t), g_fx, 4'b0010);
        end

        // Lock: master 2 locked for 20 transfers, master 0 waiting
        do_reset();
        busreq = 4'b0100;
        hlock = 4'b0100;
        tick();
        check("lk_gnt2", g_rr, 4'b0100);
        busreq = 4'b0101;
        for (int t = 0; t < 20; t++) begin
            htrans = (t % 4 == 0) ? T_NSEQ : T_SEQ;
            if (t >= 12) busreq = 4'b0001;
            tick();
            check($sformatf("lk_gnt_%0d", t), g_rr, 4'b0100);
            check($sformatf("lk_ml_%0d", t), l_rr, 1'b1);
        end
        busreq = 4'b0101;
        hlock = 4'b0000;
        htrans = T_IDLE;
        tick();
        check("lk_idle1_gnt", g_rr, 4'b0100);
        check("lk_idle1_ml", l_rr, 1'b0);
        tick();
        check("lk_release", g_rr, 4'b0001);

        // Max hold = 4: handover only at a NONSEQ boundary
        do_reset();
        busreq = 4'b0010;
        tick();
        check("mh_gnt1", g_mh, 4'b0010);
        busreq = 4'b1010;
        for (int t = 0; t < 9; t++) begin
            htrans = mh_trans[t];
            tick();
            check($sformatf("mh_gnt_%0d", t), g_mh, mh_gnt[t]);
        end
        check("mh_hm3", m_mh, 4'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
